aes_round_ctrl: RTL

Sequencer for the iterative AES-128 round datapath (state register, sub_bytes, shift_rows, mix_columns and add_round_key, with forward and INVERSE instances).
- Accepts one block request at a time, latches encrypt or decrypt mode, and steps through the initial AddRoundKey, NUM_ROUNDS-1 full rounds and a final round without MixColumns.
- Drives the datapath load/enable/mode strobes and the round-key index to the key store.
- Holds the completion flag until the consumer accepts it.

---
 rtl/aes_round_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES datapath: initial AddRoundKey, NUM_ROUNDS-1 full rounds, final round.
// Optional abort input enabled by defining AES_ROUND_CTRL_ABORT_EN.
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int IDX_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             decrypt,
    input  logic             key_ready,
    output logic [IDX_W-1:0] round_key_idx,
    output logic             dp_load,
    output logic             dp_round_en,
    output logic             dp_last_round,
    output logic             dp_inverse,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready
`ifdef AES_ROUND_CTRL_ABORT_EN
    ,
    input  logic             abort
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid is held stable by its source until that edge.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        LAST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ROUNDS);
    localparam logic [IDX_W-1:0] ROUND_END = IDX_W'(NUM_ROUNDS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mode_d        = mode_q;
        start_ready   = 1'b0;
        round_key_idx = '0;
        dp_load       = 1'b0;
        dp_round_en   = 1'b0;
        dp_last_round = 1'b0;
        done_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    mode_d  = decrypt;
                    cnt_d   = '0;
                    state_d = INIT;
                end
            end
            INIT: begin
                round_key_idx = mode_q ? LAST_IDX : '0;
                dp_load       = key_ready;
                if (key_ready) begin
                    cnt_d   = IDX_W'(1);
                    state_d = ROUND;
                end
            end
            ROUND: begin
                // Decrypt walks the key schedule backwards.
                round_key_idx = mode_q ? (LAST_IDX - cnt_q) : cnt_q;
                dp_round_en   = key_ready;
                if (key_ready) begin
                    cnt_d = cnt_q + IDX_W'(1);
                    if (cnt_q == ROUND_END) begin
                        state_d = LAST;
                    end
                end
            end
            LAST: begin
                round_key_idx = mode_q ? '0 : LAST_IDX;
                dp_round_en   = key_ready;
                dp_last_round = key_ready;
                if (key_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef AES_ROUND_CTRL_ABORT_EN
        if (abort && (state_q != IDLE)) begin
            state_d       = IDLE;
            cnt_d         = '0;
            dp_load       = 1'b0;
            dp_round_en   = 1'b0;
            dp_last_round = 1'b0;
        end
`endif
    end

    assign busy       = (state_q != IDLE);
    assign dp_inverse = mode_q;

endmodule
